// File: rtl/shift_rows_dec_serial_if.sv
// Column-serial handshake bundle for shift_rows_dec_serial: input column stream and output column stream.
// i_Mode exists only when SHIFT_ROWS_DUAL_MODE_EN is defined.
interface shift_rows_dec_serial_if;
    logic [31:0] i_Din;
    logic        i_Valid;
    logic        o_Ready;
    logic [31:0] o_Dout;
    logic        o_Valid;
    logic        i_Ready;
`ifdef SHIFT_ROWS_DUAL_MODE_EN
    logic        i_Mode;

    modport master (output i_Din, i_Valid, i_Ready, i_Mode, input o_Ready, o_Dout, o_Valid);
    modport slave  (input i_Din, i_Valid, i_Ready, i_Mode, output o_Ready, o_Dout, o_Valid);
`else
    modport master (output i_Din, i_Valid, i_Ready, input o_Ready, o_Dout, o_Valid);
    modport slave  (input i_Din, i_Valid, i_Ready, output o_Ready, o_Dout, o_Valid);
`endif
endinterface

// File: rtl/shift_rows_dec_serial.sv
// Column-serial AES InvShiftRows with two ping-pong block buffers, one column per cycle each way.
// SHIFT_ROWS_DUAL_MODE_EN adds a per-block i_Mode selecting the forward ShiftRows instead.
module shift_rows_dec_serial (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    shift_rows_dec_serial_if.slave bus
);
    localparam int unsigned COL_W    = 32;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned CNT_W    = 2;

    logic [COL_W-1:0] bank_q [2][NUM_COLS];
    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             wr_fire_c, rd_fire_c;
    logic [CNT_W-1:0] src_c;
    logic [COL_W-1:0] dout_c;
`ifdef SHIFT_ROWS_DUAL_MODE_EN
    logic [1:0]       mode_q, mode_d;
`endif

    assign wr_fire_c   = bus.i_Valid && !full_q[wr_bank_q];
    assign rd_fire_c   = full_q[rd_bank_q] && bus.i_Ready;
    assign bus.o_Ready = !full_q[wr_bank_q];
    assign bus.o_Valid = full_q[rd_bank_q];
    assign bus.o_Dout  = dout_c;

    // Bank pointers, column counters and full flags; a bank's flag is only set while empty and only cleared while full.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
`ifdef SHIFT_ROWS_DUAL_MODE_EN
        mode_d    = mode_q;
        if (wr_fire_c && (wr_cnt_q == '0)) begin
            mode_d[wr_bank_q] = bus.i_Mode;
        end
`endif
        if (wr_fire_c) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
            if (wr_cnt_q == CNT_W'(NUM_COLS - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (rd_fire_c) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
            if (rd_cnt_q == CNT_W'(NUM_COLS - 1)) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
`ifdef SHIFT_ROWS_DUAL_MODE_EN
            mode_q    <= '0;
`endif
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
`ifdef SHIFT_ROWS_DUAL_MODE_EN
            mode_q    <= mode_d;
`endif
        end
    end

    // Block storage; cleared on reset so the idle output column reads as zero.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    bank_q[b][c] <= '0;
                end
            end
        end else if (wr_fire_c) begin
            bank_q[wr_bank_q][wr_cnt_q] <= bus.i_Din;
        end
    end

    // Row r of output column c takes row r of input column c-r (inverse) or c+r (forward), mod 4.
    always_comb begin
        dout_c = '0;
        src_c  = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
`ifdef SHIFT_ROWS_DUAL_MODE_EN
            src_c = mode_q[rd_bank_q] ? (rd_cnt_q + CNT_W'(r)) : (rd_cnt_q - CNT_W'(r));
`else
            src_c = rd_cnt_q - CNT_W'(r);
`endif
            dout_c[COL_W-1-BYTE_W*r -: BYTE_W] = bank_q[rd_bank_q][src_c][COL_W-1-BYTE_W*r -: BYTE_W];
        end
    end
endmodule

// File: tb/tb_shift_rows_dec_serial.sv
// Directed self-checking bench for shift_rows_dec_serial: reset, basic vector, streaming, backpressure,
// mid-block reset, random handshakes and (with SHIFT_ROWS_DUAL_MODE_EN) forward mode.
`timescale 1ns/1ps
module tb_shift_rows_dec_serial;
    logic i_Clk = 1'b0;
    logic i_Rst;

    always #5 i_Clk = ~i_Clk;

    shift_rows_dec_serial_if bus ();

    shift_rows_dec_serial dut (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    int          rdy_mode = 1;
    int          cyc      = 0;
    bit          stream_on = 0;
    int          last_fire = -1;
    int          gaps = 0;
    int          ready_stalls = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, want %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [127:0] xform(input logic [127:0] s, input logic fwd);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = fwd ? ((c + r) % 4) : ((c - r + 4) % 4);
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    task automatic send_col(input logic [31:0] col, input logic mode, input int vpct, output bit ok);
        int budget;
        budget = 0;
        ok = 0;
        while (!ok && budget < 300) begin
            bus.i_Valid = ($urandom_range(1, 100) <= vpct);
            bus.i_Din   = bus.i_Valid ? col : $urandom;
`ifdef SHIFT_ROWS_DUAL_MODE_EN
            bus.i_Mode  = mode;
`endif
            @(negedge i_Clk);
            if (bus.i_Valid && bus.o_Ready) ok = 1;
            else if (bus.i_Valid) ready_stalls++;
            budget++;
            @(posedge i_Clk);
            #1;
        end
        bus.i_Valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk, input logic mode, input int vpct);
        bit ok;
        logic [127:0] t;
        for (int c = 0; c < 4; c++) begin
            // Mode is only meaningful on column 0; drive the opposite value elsewhere.
            send_col(blk[127-32*c -: 32], (c == 0) ? mode : ~mode, vpct, ok);
            check("accept", 32'(ok), 32'd1);
        end
        t = xform(blk, mode);
        for (int c = 0; c < 4; c++) exp_q.push_back(t[127-32*c -: 32]);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge i_Clk);
            n++;
        end
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // i_Ready driver: 0 = held low, 1 = held high, otherwise random.
    initial begin
        bus.i_Ready = 1'b1;
        forever begin
            @(posedge i_Clk);
            #1;
            case (rdy_mode)
                0:       bus.i_Ready = 1'b0;
                1:       bus.i_Ready = 1'b1;
                default: bus.i_Ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output scoreboard and stall-stability monitor.
    initial begin
        bit          hold_vld;
        logic [31:0] hold_val;
        hold_vld = 0;
        hold_val = '0;
        forever begin
            @(negedge i_Clk);
            cyc++;
            if (i_Rst) begin
                hold_vld = 0;
            end else begin
                if (hold_vld && bus.o_Valid) check("stall_hold", bus.o_Dout, hold_val);
                if (bus.o_Valid && bus.i_Ready) begin
                    if (exp_q.size() == 0) check("extra_col", 32'(exp_q.size()), 32'd1);
                    else check("dout", bus.o_Dout, exp_q.pop_front());
                    if (stream_on) begin
                        if (last_fire >= 0 && cyc - last_fire != 1) gaps++;
                        last_fire = cyc;
                    end
                    hold_vld = 0;
                end else if (bus.o_Valid) begin
                    hold_vld = 1;
                    hold_val = bus.o_Dout;
                end else begin
                    hold_vld = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] blk0, blk_a, blk_b, blk_c, blk_d, blk_e, blk_f;
        logic [127:0] t;
        bit ok;

        blk0  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        blk_a = 128'h11223344_55667788_99AABBCC_DDEEFF00;
        blk_b = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
        blk_c = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        blk_d = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        blk_e = 128'h10203040_50607080_90A0B0C0_D0E0F000;
        blk_f = 128'h3C3D3E3F_40414243_44454647_48494A4B;

        bus.i_Valid = 1'b0;
        bus.i_Din   = '0;
`ifdef SHIFT_ROWS_DUAL_MODE_EN
        bus.i_Mode  = 1'b0;
`endif
        i_Rst = 1'b1;
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        check("rst_ready", 32'(bus.o_Ready), 32'd1);
        check("rst_valid", 32'(bus.o_Valid), 32'd0);
        check("rst_dout", bus.o_Dout, 32'h0);
        @(posedge i_Clk);
        #1;
        i_Rst = 1'b0;

        // Basic vector with hand-computed columns, checked cycle by cycle.
        send_block(blk0, 1'b0, 100);
        check("lat_valid", 32'(bus.o_Valid), 32'd1);
        check("basic_c0", bus.o_Dout, 32'h000D0A07);
        @(posedge i_Clk); #1;
        check("basic_c1", bus.o_Dout, 32'h04010E0B);
        @(posedge i_Clk); #1;
        check("basic_c2", bus.o_Dout, 32'h0805020F);
        @(posedge i_Clk); #1;
        check("basic_c3", bus.o_Dout, 32'h0C090603);
        @(posedge i_Clk); #1;
        check("basic_idle", 32'(bus.o_Valid), 32'd0);
        wait_drain(20);

        // Three back-to-back blocks.
        stream_on = 1;
        last_fire = -1;
        gaps = 0;
        ready_stalls = 0;
        send_block(blk_a, 1'b0, 100);
        send_block(blk_b, 1'b0, 100);
        send_block(blk_c, 1'b0, 100);
        wait_drain(40);
        stream_on = 0;
        check("stream_gaps", 32'(gaps), 32'd0);
        check("stream_stalls", 32'(ready_stalls), 32'd0);

        // Backpressure: two blocks buffered, third is refused until a bank drains.
        rdy_mode = 0;
        repeat (2) @(posedge i_Clk);
        #1;
        send_block(blk_d, 1'b0, 100);
        send_block(blk_e, 1'b0, 100);
        bus.i_Valid = 1'b1;
        bus.i_Din   = blk_f[127:96];
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        t = xform(blk_d, 1'b0);
        check("bp_ready", 32'(bus.o_Ready), 32'd0);
        check("bp_valid", 32'(bus.o_Valid), 32'd1);
        check("bp_dout", bus.o_Dout, t[127:96]);
        @(posedge i_Clk);
        #1;
        rdy_mode = 1;
        send_block(blk_f, 1'b0, 100);
        wait_drain(60);

        // Reset with one block undrained and a partial block in the other bank.
        rdy_mode = 0;
        repeat (2) @(posedge i_Clk);
        #1;
        send_block(blk_a, 1'b0, 100);
        send_col(blk_b[127:96], 1'b0, 100, ok);
        check("accept", 32'(ok), 32'd1);
        send_col(blk_b[95:64], 1'b0, 100, ok);
        check("accept", 32'(ok), 32'd1);
        i_Rst = 1'b1;
        @(negedge i_Clk);
        check("mid_rst_valid", 32'(bus.o_Valid), 32'd0);
        check("mid_rst_ready", 32'(bus.o_Ready), 32'd1);
        check("mid_rst_dout", bus.o_Dout, 32'h0);
        exp_q.delete();
        @(posedge i_Clk);
        #1;
        i_Rst = 1'b0;
        rdy_mode = 1;
        repeat (2) @(posedge i_Clk);
        #1;
        send_block(blk_c, 1'b0, 100);
        t = xform(blk_c, 1'b0);
        check("post_rst_c0", bus.o_Dout, t[127:96]);
        wait_drain(20);
        check("post_rst_idle", 32'(bus.o_Valid), 32'd0);

        // Random handshakes with random data.
        rdy_mode = 2;
        for (int i = 0; i < 6; i++) begin
            t = {$urandom, $urandom, $urandom, $urandom};
            send_block(t, 1'b0, 60);
        end
        wait_drain(300);
        rdy_mode = 1;

`ifdef SHIFT_ROWS_DUAL_MODE_EN
        // Forward block followed immediately by an inverse block.
        repeat (2) @(posedge i_Clk);
        #1;
        send_block(blk0, 1'b1, 100);
        check("fwd_c0", bus.o_Dout, 32'h00050A0F);
        send_block(blk0, 1'b0, 100);
        wait_drain(30);
        send_block(blk_a, 1'b1, 100);
        send_block(blk_b, 1'b0, 100);
        wait_drain(30);
`endif

        repeat (4) @(posedge i_Clk);
        #1;
        check("final_empty", 32'(exp_q.size()), 32'd0);
        check("final_valid", 32'(bus.o_Valid), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
